// File: rtl/iomem_gpio_bank.sv
// PicoSoC iomem peripheral: byte-writable output banks with set/clear aliases,
// synchronised input banks, rising-edge interrupt capture and a 7-segment scanner.
module iomem_gpio_bank #(
  parameter logic [7:0] BASE     = 8'h03,
  parameter int         N_OUT    = 2,
  parameter int         N_IN     = 1,
  parameter int         N_DIGITS = 4,
  parameter int         SCAN_DIV = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  output logic [32*N_OUT-1:0] gpio_out,
  input  logic [32*N_IN-1:0]  gpio_in,
  output logic [N_DIGITS-1:0] seg_an,
  output logic [7:0]          seg_cat,
  output logic                irq
);
  localparam logic [2:0] GRP_OUT    = 3'd0;
  localparam logic [2:0] GRP_SET    = 3'd1;
  localparam logic [2:0] GRP_CLR    = 3'd2;
  localparam logic [2:0] GRP_MISC   = 3'd3;
  localparam logic [2:0] DIGIT_LAST = 3'(N_DIGITS - 1);

  logic                ready_reg;
  logic [31:0]         rdata_reg;
  logic [31:0]         rdata_next;
  logic                access;
  logic                write;
  logic [2:0]          grp;
  logic [2:0]          sub;
  logic [31:0]         byte_mask;
  logic [31:0]         wbits;
  logic [32*N_OUT-1:0] out_reg;
  logic [32*N_IN-1:0]  sync1_reg;
  logic [32*N_IN-1:0]  sync2_reg;
  logic [31:0]         prev_reg;
  logic [31:0]         stat_reg;
  logic [31:0]         stat_next;
  logic [31:0]         stat_clr;
  logic [31:0]         rise;
  logic [31:0]         mask_reg;
  logic                irq_reg;
  logic [63:0]         seg_reg;
  logic [SCAN_DIV-1:0] presc_reg;
  logic [2:0]          digit_reg;
  logic                unused_addr_bits;

  // The ready gate makes every access exactly two cycles, even with valid held.
  assign access    = iomem_valid && !ready_reg && (iomem_addr[31:24] == BASE);
  assign write     = access && (iomem_wstrb != 4'b0000);
  assign grp       = iomem_addr[7:5];
  assign sub       = iomem_addr[4:2];
  assign byte_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                      {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wbits     = iomem_wdata & byte_mask;
  assign unused_addr_bits = ^{iomem_addr[23:8], iomem_addr[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi = gi + 1) begin : g_out
      logic [31:0] bank_reg;
      logic        hit;
      assign hit = write && (sub == 3'(gi));
      always_ff @(posedge clk) begin
        if (reset) begin
          bank_reg <= '0;
        end else if (hit) begin
          case (grp)
            GRP_OUT: bank_reg <= (bank_reg & ~byte_mask) | wbits;
            GRP_SET: bank_reg <= bank_reg | wbits;
            GRP_CLR: bank_reg <= bank_reg & ~wbits;
            default: bank_reg <= bank_reg;
          endcase
        end
      end
      assign out_reg[32*gi +: 32] = bank_reg;
    end

    // Digit bytes beyond N_DIGITS are tied to zero so they read back 0.
    for (gi = 0; gi < 8; gi = gi + 1) begin : g_seg
      if (gi < N_DIGITS) begin : g_digit
        localparam logic [2:0] SEG_SUB = (gi < 4) ? 3'd6 : 3'd7;
        logic [7:0] byte_reg;
        always_ff @(posedge clk) begin
          if (reset) begin
            byte_reg <= '0;
          end else if (write && grp == GRP_MISC && sub == SEG_SUB && iomem_wstrb[gi % 4]) begin
            byte_reg <= iomem_wdata[8*(gi % 4) +: 8];
          end
        end
        assign seg_reg[8*gi +: 8] = byte_reg;
      end else begin : g_none
        assign seg_reg[8*gi +: 8] = 8'h00;
      end
    end

    for (gi = 0; gi < N_DIGITS; gi = gi + 1) begin : g_an
      assign seg_an[gi] = (digit_reg != 3'(gi));
    end
  endgenerate

  // A fresh edge overrides a coincident W1C on the same bit.
  assign rise      = sync2_reg[31:0] & ~prev_reg;
  assign stat_clr  = (write && grp == GRP_MISC && sub == 3'd4) ? wbits : 32'h0;
  assign stat_next = (stat_reg & ~stat_clr) | rise;

  always_comb begin
    rdata_next = '0;
    case (grp)
      GRP_OUT, GRP_SET, GRP_CLR: begin
        for (int k = 0; k < N_OUT; k++) begin
          if (sub == 3'(k)) rdata_next = out_reg[32*k +: 32];
        end
      end
      GRP_MISC: begin
        case (sub)
          3'd4: rdata_next = stat_reg;
          3'd5: rdata_next = mask_reg;
          3'd6: rdata_next = seg_reg[31:0];
          3'd7: rdata_next = seg_reg[63:32];
          default: begin
            for (int j = 0; j < N_IN; j++) begin
              if (sub == 3'(j)) rdata_next = sync2_reg[32*j +: 32];
            end
          end
        endcase
      end
      default: rdata_next = '0;
    endcase
  end

  always_comb begin
    seg_cat = '0;
    for (int d = 0; d < 8; d++) begin
      if (digit_reg == 3'(d)) seg_cat = seg_reg[8*d +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_reg <= 1'b0;
      rdata_reg <= '0;
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
      stat_reg  <= '0;
      mask_reg  <= '0;
      irq_reg   <= 1'b0;
      presc_reg <= '0;
      digit_reg <= '0;
    end else begin
      ready_reg <= access;
      rdata_reg <= access ? rdata_next : 32'h0;
      sync1_reg <= gpio_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg[31:0];
      stat_reg  <= stat_next;
      if (write && grp == GRP_MISC && sub == 3'd5) begin
        mask_reg <= (mask_reg & ~byte_mask) | wbits;
      end
      irq_reg   <= |(stat_reg & mask_reg);
      presc_reg <= presc_reg + SCAN_DIV'(1);
      if (&presc_reg) begin
        digit_reg <= (digit_reg == DIGIT_LAST) ? 3'd0 : digit_reg + 3'd1;
      end
    end
  end

  assign iomem_ready = ready_reg;
  assign iomem_rdata = rdata_reg;
  assign gpio_out    = out_reg;
  assign irq         = irq_reg;
endmodule

// File: doc/iomem_gpio_bank.md
# iomem_gpio_bank

Parametrised memory-mapped I/O peripheral for the PicoSoC `iomem` bus, replacing the fixed two-bank GPIO/DIP/7-segment logic in board top levels.
- Provides N_OUT byte-writable output banks with set/clear aliases and N_IN synchronised input banks.
- Adds rising-edge interrupt capture on input bank 0 and a multiplexed 7-segment scanner with parametrised digit count.
- Sits between `picosoc` iomem ports and board pins; irq feeds one of `irq_5..7`.

## Interface
Parameters:
- BASE, 8'h03: value of iomem_addr[31:24] this block decodes.
- N_OUT, 2: output banks, 1..8.
- N_IN, 1: input banks, 1..4.
- N_DIGITS, 4: 7-segment digits, 1..8.
- SCAN_DIV, 15: digit advances every 2^SCAN_DIV clocks, 1..24.

Ports:
- clk  in  1  system clock; one clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- iomem_valid  in  1  bus request.
- iomem_ready  out  1  one-cycle acknowledge.
- iomem_wstrb  in  4  byte write strobes; 0 = read.
- iomem_addr  in  32  byte address.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  read data, valid while iomem_ready=1.
- gpio_out  out  32*N_OUT  output banks; bank k = bits [32k+31:32k].
- gpio_in  in  32*N_IN  asynchronous input pins.
- seg_an  out  N_DIGITS  digit enables, active-low one-hot.
- seg_cat  out  8  segment data for the active digit.
- irq  out  1  level interrupt.

## Operation
Decode:
- Selected when iomem_addr[31:24]==BASE; register index = iomem_addr[7:2].
- Non-matching addresses: no response (ready stays 0).

Register map (offsets):
- 0x00+4k OUT[k]: RW, byte-strobed.
- 0x20+4k SET[k]: write-1-sets bits of OUT[k]; reads return OUT[k].
- 0x40+4k CLR[k]: write-1-clears bits of OUT[k]; reads return OUT[k].
- 0x60+4j IN[j]: RO synchronised input.
- 0x70 IRQ_STAT: sticky rising-edge flags of IN[0]; W1C.
- 0x74 IRQ_MASK: RW.
- 0x78 SEG0: digits 0..3, byte d = digit d.
- 0x7C SEG1: digits 4..7.

Access rules:
- Byte strobes apply to every writable register, including SET/CLR/W1C; unstrobed bytes are unchanged.
- In-window but unimplemented offsets (k≥N_OUT, j≥N_IN, digit bytes ≥N_DIGITS) are acknowledged, read 0, and ignore writes.
- Read data is the register value before the write in the same access.

Inputs and interrupt:
- Each gpio_in bit passes through a 2-flop synchroniser; IN[j] is the second stage.
- A third register holds the previous IN[0]; IRQ_STAT[b] sets when IN[0][b]=1 and prev[b]=0.
- If an edge and a W1C hit the same bit in the same cycle, set wins.
- irq = |(IRQ_STAT & IRQ_MASK), registered.

Scanner:
- Prescaler of SCAN_DIV bits increments every cycle.
- At terminal count, digit index advances, wrapping N_DIGITS-1 -> 0.
- seg_an = ~(1<<digit); seg_cat = SEG byte[digit].

## Timing
- Reset (sync, active-high): iomem_ready=0, iomem_rdata=0, all OUT/IRQ_STAT/IRQ_MASK/SEG=0, synchronisers and prev=0, prescaler=0, digit=0, irq=0, seg_an=~1, seg_cat=0.
- Handshake: valid && !ready && selected at edge E -> ready=1 for exactly the cycle after E, rdata valid then. Register update at E. Ready is 0 in the following cycle even if valid stays high; back-to-back accesses therefore take 2 cycles each.
- Reset asserted mid-access: ready drops next edge, write not applied if reset is high at E.
- Input latency: pin change sampled at E1 -> IN visible after E2 -> IRQ_STAT set at E3 -> irq high after E4.
- Scan: digit changes once per 2^SCAN_DIV cycles; first advance 2^SCAN_DIV cycles after reset release.

## Test plan
- Write 0xA5A5A5A5 to OUT[1] with wstrb=4'b0011, then read -> rdata 0x0000A5A5, gpio_out[63:32]=0x0000A5A5; ready high exactly 1 cycle per access.
- OUT[0]=0x0000FF00; write SET[0]=0x0000000F then CLR[0]=0x00000F00 -> OUT[0]=0x0000F00F.
- IRQ_MASK=1; drive gpio_in[0] 0->1 -> IRQ_STAT=1 three edges later, irq high one edge after that; W1C of 1 coincident with a new edge on bit 0 -> bit stays 1.
- Address with [31:24]≠BASE -> no ready for 10 cycles; read of offset 0x2C with N_OUT=2 -> ready, rdata 0.
- SCAN_DIV=2, N_DIGITS=3, SEG0=0x00332211 -> seg_an cycles 110,101,011 every 4 cycles with seg_cat 11,22,33, then wraps.
- Assert reset during an outstanding write -> write not applied, all outputs at reset values next cycle.
